// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake bundle for uart_rx_fifo: head frame, its error
// flags and the valid/ready pair. The receiver is the master.
interface uart_rx_fifo_if #(
    parameter int MAX_WIDTH = 8
);
    logic                 DATA_VALID_RX;
    logic                 DATA_READY_RX;
    logic [MAX_WIDTH-1:0] P_DATA_RX;
    logic                 par_err;
    logic                 stp_err;

    modport master (
        output DATA_VALID_RX,
        output P_DATA_RX,
        output par_err,
        output stp_err,
        input  DATA_READY_RX
    );

    modport slave (
        input  DATA_VALID_RX,
        input  P_DATA_RX,
        input  par_err,
        input  stp_err,
        output DATA_READY_RX
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with 3-sample majority vote,
// runtime frame format and a frame FIFO with overrun reporting.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
    parameter int MAX_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK_RX,
    input  logic                  RST_RX,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP_2,
    uart_rx_fifo_if.master        rx_bus,
    output logic                  ovr_err,
    output logic                  brk_det
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = MAX_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                state;
    logic                  rx_meta, rx_s;
    logic [PRESCALE_W-1:0] edge_cnt, presc_l;
    logic [3:0]            bit_cnt, len_l, len_clamped;
    logic                  par_en_l, par_typ_l, stp2_l;
    logic [2:0]            smp;
    logic [MAX_WIDTH-1:0]  data_sr;
    logic                  par_err_r, stp_err_r;
    logic                  maj, at_dec, at_end;
    logic [PRESCALE_W-1:0] half_p;
    logic                  push_req, push_stp, push_ok, pop, full, empty;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [EW-1:0]         head;

    assign half_p      = {1'b0, presc_l[PRESCALE_W-1:1]};
    assign at_dec      = (edge_cnt == half_p + PRESCALE_W'(2));
    assign at_end      = (edge_cnt == presc_l - PRESCALE_W'(1));
    assign maj         = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign len_clamped = (DATA_LEN < 4'd5 || DATA_LEN > 4'(MAX_WIDTH)) ? 4'(MAX_WIDTH) : DATA_LEN;

`ifdef UART_RX_BREAK_DET_EN
    logic brk_hit, brk_wait, par_bit;
    assign brk_hit = (state == STOP1) && at_dec && !maj && (data_sr == '0) && (!par_en_l || !par_bit);
`endif

    // Two-flop synchroniser for the asynchronous serial line, idling high
    always_ff @(posedge CLK_RX) begin
        if (RST_RX) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // A frame is pushed at the decision point of its final stop bit
    always_comb begin
        push_req = 1'b0;
        push_stp = stp_err_r;
        if (at_dec && state == STOP1 && !stp2_l) begin
            push_req = 1'b1;
            push_stp = ~maj;
        end else if (at_dec && state == STOP2) begin
            push_req = 1'b1;
            push_stp = stp_err_r | ~maj;
        end
`ifdef UART_RX_BREAK_DET_EN
        if (brk_hit) push_req = 1'b0;
`endif
    end

    // Receiver FSM: bit timing, majority sampling, data assembly and error flags
    always_ff @(posedge CLK_RX) begin
        if (RST_RX) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            presc_l   <= '0;
            len_l     <= 4'(MAX_WIDTH);
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            stp2_l    <= 1'b0;
            smp       <= 3'b111;
            data_sr   <= '0;
            par_err_r <= 1'b0;
            stp_err_r <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_wait  <= 1'b0;
            par_bit   <= 1'b0;
            brk_det   <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_DET_EN
            brk_det <= brk_hit;
`endif
            if (state != IDLE) begin
                edge_cnt <= at_end ? '0 : edge_cnt + PRESCALE_W'(1);
                if (edge_cnt == half_p - PRESCALE_W'(1)) smp[0] <= rx_s;
                if (edge_cnt == half_p)                  smp[1] <= rx_s;
                if (edge_cnt == half_p + PRESCALE_W'(1)) smp[2] <= rx_s;
            end
            case (state)
                IDLE: begin
                    presc_l   <= PRESCALE;
                    len_l     <= len_clamped;
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                    stp2_l    <= STP_2;
                    bit_cnt   <= '0;
                    data_sr   <= '0;
                    par_err_r <= 1'b0;
                    stp_err_r <= 1'b0;
                    edge_cnt  <= '0;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit   <= 1'b0;
                    if (brk_wait) begin
                        if (rx_s && edge_cnt == presc_l - PRESCALE_W'(1)) begin
                            brk_wait <= 1'b0;
                        end else if (rx_s) begin
                            edge_cnt <= edge_cnt + PRESCALE_W'(1);
                        end
                    end else if (!rx_s) begin
                        state <= START;
                    end
`else
                    if (!rx_s) state <= START;
`endif
                end
                START: begin
                    if (at_dec && maj) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (at_dec) data_sr <= data_sr | (MAX_WIDTH'(maj) << bit_cnt);
                    if (at_end) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == len_l - 4'd1) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP1;
                        end
                    end
                end
                PARITY: begin
                    if (at_dec) begin
                        par_err_r <= ((^data_sr) ^ maj) != par_typ_l;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit   <= maj;
`endif
                    end
                    if (at_end) state <= STOP1;
                end
                STOP1: begin
                    if (at_dec) begin
                        stp_err_r <= ~maj;
`ifdef UART_RX_BREAK_DET_EN
                        if (brk_hit) begin
                            state    <= IDLE;
                            edge_cnt <= '0;
                            brk_wait <= 1'b1;
                        end else
`endif
                        if (!stp2_l) begin
                            state    <= IDLE;
                            edge_cnt <= '0;
                        end
                    end else if (at_end) begin
                        state <= STOP2;
                    end
                end
                STOP2: begin
                    if (at_dec) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_BREAK_DET_EN
    assign brk_det = 1'b0;
`endif

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && rx_bus.DATA_READY_RX;
    assign push_ok = push_req && (!full || pop);

    // Frame storage; contents are only visible through the valid-gated head
    always_ff @(posedge CLK_RX) begin
        if (!RST_RX && push_ok) mem[wr_ptr[AW-1:0]] <= {data_sr, par_err_r, push_stp};
    end

    // FIFO pointers and the one-cycle overrun pulse for dropped frames
    always_ff @(posedge CLK_RX) begin
        if (RST_RX) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovr_err <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            ovr_err <= push_req && full && !pop;
        end
    end

    assign head                 = mem[rd_ptr[AW-1:0]];
    assign rx_bus.DATA_VALID_RX = !empty;
    assign rx_bus.P_DATA_RX     = empty ? '0 : head[EW-1:2];
    assign rx_bus.par_err       = !empty && head[1];
    assign rx_bus.stp_err       = !empty && head[0];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo. Directed frames push
// hand-computed expectations; a negedge monitor compares every popped frame.
module tb_uart_rx_fifo;
    localparam int MAX_WIDTH  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PRESCALE_W = 6;
    localparam int BIT_CLKS   = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       stp;
    } exp_t;

    logic                  CLK_RX = 1'b0;
    logic                  RST_RX;
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic [3:0]            DATA_LEN;
    logic                  PAR_EN, PAR_TYP, STP_2;
    logic                  ovr_err, brk_det;

    exp_t expq[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   ovr_count = 0;
    int   brk_count = 0;
    int   pop_count = 0;
    int   cyc = 0;
    int   valid_rise_cyc = 0;
    logic prev_valid = 1'b0;

    uart_rx_fifo_if #(.MAX_WIDTH(MAX_WIDTH)) rx_bus ();

    uart_rx_fifo #(
        .MAX_WIDTH (MAX_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .CLK_RX  (CLK_RX),
        .RST_RX  (RST_RX),
        .RX_IN   (RX_IN),
        .PRESCALE(PRESCALE),
        .DATA_LEN(DATA_LEN),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .STP_2   (STP_2),
        .rx_bus  (rx_bus),
        .ovr_err (ovr_err),
        .brk_det (brk_det)
    );

    always #5 CLK_RX = ~CLK_RX;

    always @(posedge CLK_RX) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted frame and counts pulses
    always @(negedge CLK_RX) begin
        if (rx_bus.DATA_VALID_RX && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = rx_bus.DATA_VALID_RX;
        if (!RST_RX) begin
            if (ovr_err) ovr_count++;
            if (brk_det) brk_count++;
            if (rx_bus.DATA_VALID_RX && rx_bus.DATA_READY_RX) begin
                pop_count++;
                if (expq.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected frame: got data 0x%0h, required no frame", rx_bus.P_DATA_RX);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    checkOutput("pop data", 32'(rx_bus.P_DATA_RX), 32'(e.data));
                    checkOutput("pop par_err", 32'(rx_bus.par_err), 32'(e.par));
                    checkOutput("pop stp_err", 32'(rx_bus.stp_err), 32'(e.stp));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_RX);
        #1;
    endtask

    task automatic sendBit(input logic b, input logic spike);
        RX_IN = b;
        if (spike) begin
            tick(5);
            RX_IN = ~b;
            tick(1);
            RX_IN = b;
            tick(BIT_CLKS - 6);
        end else begin
            tick(BIT_CLKS);
        end
    endtask

    task automatic setConfig(input int len, input logic par_en, input logic par_typ, input logic stp2);
        PRESCALE = PRESCALE_W'(BIT_CLKS);
        DATA_LEN = 4'(len);
        PAR_EN   = par_en;
        PAR_TYP  = par_typ;
        STP_2    = stp2;
        tick(2);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic par_bit, input logic stop1,
                                 input logic stop2, input int spike_bit, input logic expect_push,
                                 input logic [7:0] exp_data, input logic exp_par, input logic exp_stp);
        exp_t e;
        if (expect_push) begin
            e.data = exp_data;
            e.par  = exp_par;
            e.stp  = exp_stp;
            expq.push_back(e);
        end
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < int'(DATA_LEN); i++) sendBit(data[i], i == spike_bit);
        if (PAR_EN) sendBit(par_bit, 1'b0);
        sendBit(stop1, 1'b0);
        if (STP_2) sendBit(stop2, 1'b0);
        RX_IN = 1'b1;
        tick(2 * BIT_CLKS);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rx_bus.DATA_READY_RX = 1'b1;
        while (rx_bus.DATA_VALID_RX && n < 40) begin
            tick(1);
            n++;
        end
        checkOutput(name, 32'(rx_bus.DATA_VALID_RX), 32'd0);
    endtask

    initial begin
        int start_cyc, pops0, brk0;
        RST_RX = 1'b1;
        RX_IN  = 1'b1;
        rx_bus.DATA_READY_RX = 1'b0;
        PRESCALE = PRESCALE_W'(BIT_CLKS);
        DATA_LEN = 4'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STP_2 = 1'b0;
        tick(3);
        RST_RX = 1'b0;
        tick(1);
        checkOutput("reset valid", 32'(rx_bus.DATA_VALID_RX), 32'd0);
        checkOutput("reset data", 32'(rx_bus.P_DATA_RX), 32'd0);
        checkOutput("reset ovr_err", 32'(ovr_err), 32'd0);
        checkOutput("reset brk_det", 32'(brk_det), 32'd0);

        // Basic 8N1 frame, latency and hold-while-stalled
        setConfig(8, 1'b0, 1'b0, 1'b0);
        start_cyc = cyc;
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("valid latency in window",
                    32'((valid_rise_cyc - start_cyc) >= 79 && (valid_rise_cyc - start_cyc) <= 85), 32'd1);
        tick(5);
        checkOutput("held data while stalled", 32'(rx_bus.P_DATA_RX), 32'hA5);
        rx_bus.DATA_READY_RX = 1'b1;
        tick(1);
        rx_bus.DATA_READY_RX = 1'b0;
        checkOutput("valid drops after pop", 32'(rx_bus.DATA_VALID_RX), 32'd0);

        // Parity, even then odd
        rx_bus.DATA_READY_RX = 1'b1;
        setConfig(8, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, -1, 1'b1, 8'h3C, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h3C, 1'b0, 1'b0);
        setConfig(8, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, -1, 1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h3C, 1'b1, 1'b0);

        // Five data bits with two stop bits; second frame has a bad second stop
        setConfig(5, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h1F, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h1F, 1'b0, 1'b0);
        applyStimulus(8'hEA, 1'b0, 1'b1, 1'b0, -1, 1'b1, 8'h0A, 1'b0, 1'b1);

        // Short glitch is rejected; mid-bit spikes are voted away
        setConfig(8, 1'b0, 1'b0, 1'b0);
        RX_IN = 1'b0;
        tick(3);
        RX_IN = 1'b1;
        tick(5 * BIT_CLKS);
        checkOutput("glitch pushes nothing", 32'(rx_bus.DATA_VALID_RX), 32'd0);
        applyStimulus(8'h96, 1'b0, 1'b1, 1'b1, 3, 1'b1, 8'h96, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b1, 0, 1'b1, 8'h01, 1'b0, 1'b0);

        // Overrun: four frames fill the FIFO, the fifth is dropped
        rx_bus.DATA_READY_RX = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(8'h44, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h44, 1'b0, 1'b0);
        checkOutput("no overrun before frame 5", 32'(ovr_count), 32'd0);
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("one overrun at frame 5", 32'(ovr_count), 32'd1);
        checkOutput("head unchanged by overrun", 32'(rx_bus.P_DATA_RX), 32'h11);
        pops0 = pop_count;
        drain("overrun drain completes");
        checkOutput("overrun drain pop count", 32'(pop_count - pops0), 32'd4);

        // Reset during DATA clears the FIFO and all outputs
        rx_bus.DATA_READY_RX = 1'b0;
        applyStimulus(8'hC3, 1'b0, 1'b1, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("frame held before reset", 32'(rx_bus.P_DATA_RX), 32'hC3);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0);
        RST_RX = 1'b1;
        tick(1);
        checkOutput("mid-frame reset valid", 32'(rx_bus.DATA_VALID_RX), 32'd0);
        checkOutput("mid-frame reset data", 32'(rx_bus.P_DATA_RX), 32'd0);
        checkOutput("mid-frame reset flags",
                    32'({rx_bus.par_err, rx_bus.stp_err, ovr_err, brk_det}), 32'd0);
        RST_RX = 1'b0;
        RX_IN = 1'b1;
        tick(3 * BIT_CLKS);
        rx_bus.DATA_READY_RX = 1'b1;
        setConfig(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h55, 1'b0, 1'b0);

        // All-zero frame with a zero stop bit
        brk0 = brk_count;
`ifdef UART_RX_BREAK_DET_EN
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("break pulse count", 32'(brk_count - brk0), 32'd1);
        checkOutput("break not pushed", 32'(rx_bus.DATA_VALID_RX), 32'd0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, -1, 1'b1, 8'h5A, 1'b0, 1'b0);
`else
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'h00, 1'b0, 1'b1);
        checkOutput("brk_det stays low", 32'(brk_count - brk0), 32'd0);
`endif

        tick(10);
        checkOutput("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Next-generation UART receiver for the UART subsystem. It oversamples the serial line with a runtime PRESCALE and takes a 3-sample majority vote per bit. Data length (5..MAX_WIDTH bits), parity mode and stop-bit count are runtime configurable. Received frames and their error flags are buffered in a parametrised FIFO, read through a valid/ready handshake, with overrun reporting.

Parameters:
MAX_WIDTH, 8, maximum data bits per frame (legal 5..9); P_DATA_RX width.
FIFO_DEPTH, 4, frame entries buffered (power of 2, >= 2).
PRESCALE_W, 6, width of PRESCALE.

Ports:
CLK_RX  input  1  receiver clock.
RST_RX  input  1  synchronous, active-high reset.
RX_IN  input  1  asynchronous serial line, idle high.
PRESCALE  input  PRESCALE_W  clocks per bit; legal even values 8..2^PRESCALE_W-2; sampled only in IDLE.
DATA_LEN  input  4  data bits per frame, 5..MAX_WIDTH; out-of-range clamps to MAX_WIDTH.
PAR_EN  input  1  1 = parity bit present.
PAR_TYP  input  1  0 = even, 1 = odd.
STP_2  input  1  1 = two stop bits.
DATA_READY_RX  input  1  consumer accepts the FIFO head.
DATA_VALID_RX  output  1  FIFO not empty.
P_DATA_RX  output  MAX_WIDTH  head data, LSB = first received bit, unused MSBs zero.
par_err  output  1  head frame's parity error flag.
stp_err  output  1  head frame's stop error flag.
ovr_err  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
brk_det  output  1  break pulse (optional feature).

Behaviour:
- Reset (synchronous, high): FSM to IDLE, counters 0, synchroniser stages to 1, FIFO empty. DATA_VALID_RX=0, P_DATA_RX=0, par_err=0, stp_err=0, ovr_err=0, brk_det=0. Reset mid-frame discards the partial frame and the FIFO contents.
- RX_IN passes through a 2-FF synchroniser (rx_s). All decisions use rx_s.
- edge_cnt counts 0..PRESCALE-1, then wraps to 0 and increments bit_cnt. The sample registers capture rx_s at edge_cnt = P/2-1, P/2 and P/2+1 (P = latched PRESCALE). The bit decision is the majority of these three and is valid at edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: PRESCALE, DATA_LEN, PAR_EN, PAR_TYP and STP_2 are latched every cycle. On the first cycle with rx_s=0, go to START with edge_cnt=0.
- START: at the decision point, bit=1 is a glitch: return to IDLE, nothing pushed. bit=0: go to DATA after the bit period ends.
- DATA: shift bits in LSB first for DATA_LEN bits, then go to PARITY if PAR_EN, else STOP1.
- PARITY: parity error when the XOR of the data bits and the parity bit is not PAR_TYP.
- STOP1: stp_err when the sampled bit is 0. If STP_2, go to STOP2 after the bit period; STOP2 ORs its own check into stp_err.
- Frame push: at the decision point of the final stop bit, the frame is pushed {data, par_err, stp_err} and the FSM returns to IDLE the same edge. The next start edge is honoured from the following cycle.
- DATA_VALID_RX rises the cycle after the push when the FIFO was empty.
- Handshake: a pop occurs on a cycle with DATA_VALID_RX & DATA_READY_RX. The head advances on the next edge. Outputs are held stable while DATA_VALID_RX=1 and DATA_READY_RX=0.
- Simultaneous push and pop when full: the pop frees the slot, the push succeeds and ovr_err stays 0.
- Push when full without a pop: the frame is dropped, ovr_err=1 for one cycle and FIFO contents are unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and LSBs equal; empty = pointers equal.

Optional Feature:
UART_RX_BREAK_DET_EN defined:
- A frame whose data bits, parity bit (if any) and first stop bit all sample 0 is a break.
- On a break: brk_det pulses 1 cycle at the stop decision point and the frame is not pushed.
- The FSM then waits in IDLE until rx_s=1 for one full bit period before it accepts a new start.

UART_RX_BREAK_DET_EN undefined:
- brk_det is tied to 0.
- A break is pushed as data 0 with stp_err=1.

Test Plan:
- PRESCALE=8, DATA_LEN=8, PAR_EN=0: send 0xA5 with 1 stop bit -> DATA_VALID_RX=1 about 80 clocks after the start edge, P_DATA_RX=0xA5, par_err=0, stp_err=0; DATA_READY_RX=1 for 1 cycle -> DATA_VALID_RX=0.
- PAR_EN=1, PAR_TYP=0 (even): send 0x3C with parity bit 1 -> par_err=1; with parity bit 0 -> par_err=0. Repeat with PAR_TYP=1 and the inverse result is required.
- DATA_LEN=5, STP_2=1: send 0x1F, then a frame whose second stop bit is 0 -> first entry 0x1F with no errors; second entry stp_err=1, P_DATA_RX[7:5]=0.
- Glitch and noise: a 3-clock low pulse on an idle line -> nothing pushed. A single-clock inverted spike at edge_cnt=P/2 inside a data bit -> the majority vote still yields the correct byte.
- Overrun: FIFO_DEPTH=4, DATA_READY_RX=0, send 5 frames -> ovr_err pulses once at frame 5. Draining gives frames 1..4 in order.
- Reset mid-frame: assert RST_RX during DATA -> all outputs 0 on the next edge. A following clean frame 0x55 is received correctly. With UART_RX_BREAK_DET_EN defined, a 0x00 frame with stop bit 0 -> brk_det=1 and no push.
